// File: rtl/decode_writeback_if.sv
// Decode/writeback bus between the fetch/execute stages and the register file block.
// master: drives the retiring instruction (wb_en, icode, rA, rB, cnd, valE, valM) and
//         observes decoded IDs, operand reads and status.
// slave:  the decode_writeback block itself.
interface decode_writeback_if;
  // Instruction being presented for decode/commit
  logic        wb_en;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  // Decoded register IDs, operands and status
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valA;
  logic [63:0] valB;
  logic        halted;
  logic [63:0] retired;

  modport master (
    output wb_en, icode, rA, rB, cnd, valE, valM,
    input  srcA, srcB, dstE, dstM, valA, valB, halted, retired
  );

  modport slave (
    input  wb_en, icode, rA, rB, cnd, valE, valM,
    output srcA, srcB, dstE, dstM, valA, valB, halted, retired
  );
endinterface

// File: rtl/decode_writeback.sv
// Y86-64 style decode and writeback stage with a 15 x 64-bit register file.
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - decode_writeback_if.slave: instruction fields and commit data in; decoded
//            register IDs, operand values (combinational), halted and retired count out.
// ID 4'hF means "no register": never written, reads as zero.
module decode_writeback #(
  parameter logic [63:0] RESET_RSP = 64'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  decode_writeback_if.slave   bus
);

  localparam logic [3:0] RegNone = 4'hF;
  localparam logic [3:0] RegRsp  = 4'h4;

  logic [63:0] r_regs [15];
  logic        r_halted;
  logic [63:0] r_retired;

  logic [3:0]  w_src_a;
  logic [3:0]  w_src_b;
  logic [3:0]  w_dst_e;
  logic [3:0]  w_dst_m;
  logic        w_legal;
  logic        w_accept;
  logic        w_wr_e;
  logic        w_wr_m;

  // Register ID decode
  always_comb begin
    w_src_a = RegNone;
    w_src_b = RegNone;
    w_dst_e = RegNone;
    w_dst_m = RegNone;

    case (bus.icode)
      4'h2, 4'h4, 4'h6, 4'hA: w_src_a = bus.rA;
      4'h9, 4'hB:             w_src_a = RegRsp;
      default:                ;
    endcase

    case (bus.icode)
      4'h4, 4'h5, 4'h6:       w_src_b = bus.rB;
      4'h8, 4'h9, 4'hA, 4'hB: w_src_b = RegRsp;
      default:                ;
    endcase

    case (bus.icode)
      4'h3, 4'h6:             w_dst_e = bus.rB;
      4'h2:                   w_dst_e = bus.cnd ? bus.rB : RegNone;  // cmovXX not taken
      4'h8, 4'h9, 4'hA, 4'hB: w_dst_e = RegRsp;
      default:                ;
    endcase

    case (bus.icode)
      4'h5, 4'hB: w_dst_m = bus.rA;
      default:    ;
    endcase
  end

  assign w_legal  = (bus.icode <= 4'hB);
  assign w_accept = bus.wb_en && !r_halted;
  // popq %rsp: dstE == dstM, the memory value wins
  assign w_wr_e   = w_accept && w_legal && (w_dst_e != RegNone) && (w_dst_e != w_dst_m);
  assign w_wr_m   = w_accept && w_legal && (w_dst_m != RegNone);

  // Register file; reads below see pre-edge contents (no forwarding)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= (i == 4) ? RESET_RSP : 64'h0;
      end
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (w_wr_m && (w_dst_m == 4'(i))) begin
          r_regs[i] <= bus.valM;
        end else if (w_wr_e && (w_dst_e == 4'(i))) begin
          r_regs[i] <= bus.valE;
        end
      end
    end
  end

  // Status: illegal icode halts without retiring; halt retires then halts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted  <= 1'b0;
      r_retired <= 64'h0;
    end else if (w_accept) begin
      if (!w_legal) begin
        r_halted <= 1'b1;
      end else begin
        r_retired <= r_retired + 64'd1;
        if (bus.icode == 4'h0) begin
          r_halted <= 1'b1;
        end
      end
    end
  end

  assign bus.srcA    = w_src_a;
  assign bus.srcB    = w_src_b;
  assign bus.dstE    = w_dst_e;
  assign bus.dstM    = w_dst_m;
  assign bus.valA    = (w_src_a == RegNone) ? 64'h0 : r_regs[w_src_a];
  assign bus.valB    = (w_src_b == RegNone) ? 64'h0 : r_regs[w_src_b];
  assign bus.halted  = r_halted;
  assign bus.retired = r_retired;

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed checks with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_decode_writeback;

  localparam logic [63:0] Rsp0 = 64'h1000;

  logic clk;
  logic rst_n;
  logic chk_on;
  int   total;
  int   bad;

  decode_writeback_if bus ();

  decode_writeback #(
    .RESET_RSP (Rsp0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [63:0] m_regs [16];  // entry 15 stays zero: "none" reads as 0
  logic        m_halted;
  logic [63:0] m_retired;

  function automatic logic [3:0] x_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] x_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] x_dst_e(input logic [3:0] ic, input logic [3:0] rb,
                                         input logic c);
    if (ic inside {4'h3, 4'h6}) return rb;
    if (ic == 4'h2) return c ? rb : 4'hF;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] x_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] de;
    logic [3:0] dm;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 64'h0;
      m_regs[4] = Rsp0;
      m_halted  = 1'b0;
      m_retired = 64'h0;
    end else if (bus.wb_en === 1'b1 && !m_halted) begin
      if (bus.icode > 4'hB) begin
        m_halted = 1'b1;
      end else begin
        m_retired = m_retired + 64'd1;
        if (bus.icode == 4'h0) m_halted = 1'b1;
        de = x_dst_e(bus.icode, bus.rB, bus.cnd);
        dm = x_dst_m(bus.icode, bus.rA);
        if (de != 4'hF) m_regs[de] = bus.valE;
        if (dm != 4'hF) m_regs[dm] = bus.valM;  // applied last so valM wins on a clash
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] sa;
    logic [3:0] sb;
    if (chk_on) begin
      sa = x_src_a(bus.icode, bus.rA);
      sb = x_src_b(bus.icode, bus.rB);
      chk("srcA", 64'(bus.srcA), 64'(sa));
      chk("srcB", 64'(bus.srcB), 64'(sb));
      chk("dstE", 64'(bus.dstE), 64'(x_dst_e(bus.icode, bus.rB, bus.cnd)));
      chk("dstM", 64'(bus.dstM), 64'(x_dst_m(bus.icode, bus.rA)));
      chk("valA", bus.valA, m_regs[sa]);
      chk("valB", bus.valB, m_regs[sb]);
      chk("halted", 64'(bus.halted), 64'(m_halted));
      chk("retired", bus.retired, m_retired);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                     input logic c, input logic [63:0] ve, input logic [63:0] vm,
                     input logic en);
    bus.icode = ic;
    bus.rA    = ra;
    bus.rB    = rb;
    bus.cnd   = c;
    bus.valE  = ve;
    bus.valM  = vm;
    bus.wb_en = en;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic hold;
    total  = 0;
    bad    = 0;
    chk_on = 1'b0;
    rst_n  = 1'b0;
    drv(4'h8, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    repeat (2) step();
    #1;
    chk("reset rsp", bus.valB, Rsp0);
    chk("reset retired", bus.retired, 64'h0);
    chk("reset halted", 64'(bus.halted), 64'h0);
    chk("model reset rsp", m_regs[4], Rsp0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // irmovq $5, %r2 -- accepted on the first edge after reset release
    drv(4'h3, 4'hF, 4'h2, 1'b0, 64'd5, 64'h0, 1'b1);
    #1 chk("irmovq dstE", 64'(bus.dstE), 64'h2);
    step();
    drv(4'h6, 4'h2, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0);
    #1 chk("irmovq r2", bus.valA, 64'd5);
    chk("irmovq retired", bus.retired, 64'd1);
    chk("model r2", m_regs[2], 64'd5);

    // OPq %r2, %r3
    drv(4'h3, 4'hF, 4'h3, 1'b0, 64'd7, 64'h0, 1'b1);
    step();
    drv(4'h6, 4'h2, 4'h3, 1'b0, 64'd12, 64'h0, 1'b1);
    #1 chk("opq valA", bus.valA, 64'd5);
    chk("opq valB", bus.valB, 64'd7);
    chk("opq srcA", 64'(bus.srcA), 64'h2);
    chk("opq srcB", 64'(bus.srcB), 64'h3);
    step();
    drv(4'h6, 4'h3, 4'h3, 1'b0, 64'h0, 64'h0, 1'b0);
    #1 chk("opq r3", bus.valA, 64'd12);
    chk("model r3", m_regs[3], 64'd12);

    // cmovXX not taken, then taken
    drv(4'h2, 4'h0, 4'h1, 1'b0, 64'd99, 64'h0, 1'b1);
    #1 chk("cmov nt dstE", 64'(bus.dstE), 64'hF);
    step();
    drv(4'h6, 4'h1, 4'h1, 1'b0, 64'h0, 64'h0, 1'b0);
    #1 chk("cmov nt r1", bus.valA, 64'h0);
    drv(4'h2, 4'h0, 4'h1, 1'b1, 64'd9, 64'h0, 1'b1);
    #1 chk("cmov t dstE", 64'(bus.dstE), 64'h1);
    step();
    drv(4'h6, 4'h1, 4'h1, 1'b0, 64'h0, 64'h0, 1'b0);
    #1 chk("cmov t r1", bus.valA, 64'd9);

    // popq %rsp
    drv(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hAA, 1'b1);
    #1 chk("popq dstM", 64'(bus.dstM), 64'h4);
    step();
    drv(4'h8, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    #1 chk("popq rsp", bus.valB, 64'hAA);
    chk("popq retired", bus.retired, 64'd6);
    chk("model rsp", m_regs[4], 64'hAA);

    // halt, then ignored commit, then asynchronous reset
    drv(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b1);
    step();
    #1 chk("halt halted", 64'(bus.halted), 64'h1);
    chk("halt retired", bus.retired, 64'd7);
    drv(4'h3, 4'hF, 4'h2, 1'b0, 64'd77, 64'h0, 1'b1);
    step();
    drv(4'h6, 4'h2, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0);
    #1 chk("halted no write", bus.valA, 64'd5);
    chk("halted retired frozen", bus.retired, 64'd7);
    drv(4'h8, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    rst_n = 1'b0;
    #1 chk("async rst halted", 64'(bus.halted), 64'h0);
    chk("async rst retired", bus.retired, 64'h0);
    chk("async rst rsp", bus.valB, Rsp0);
    rst_n = 1'b1;

    // illegal icode
    drv(4'hE, 4'h1, 4'h2, 1'b1, 64'd55, 64'd66, 1'b1);
    step();
    #1 chk("illegal halted", 64'(bus.halted), 64'h1);
    chk("illegal retired", bus.retired, 64'h0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // randomized traffic
    hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      logic [3:0]  ic;
      logic [3:0]  ra;
      logic [3:0]  rb;
      step();
      if (hold) begin
        rst_n = 1'b1;
        hold  = 1'b0;
      end
      r = $urandom_range(0, 99);
      if (r < 3)      ic = 4'h0;
      else if (r < 6) ic = 4'($urandom_range(12, 15));
      else            ic = 4'($urandom_range(1, 11));
      ra = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      rb = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      drv(ic, ra, rb, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          ($urandom_range(0, 3) != 0));
      if (m_halted && $urandom_range(0, 3) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end else if ($urandom_range(0, 127) == 0) begin
        rst_n = 1'b0;  // held across the next edge: that commit is discarded
        hold  = 1'b1;
      end
    end
    step();
    rst_n = 1'b1;
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
